// File: rtl/lemming_world.sv
// Closed-loop environment for a walking/falling lemming controller: a 1-D strip with end walls
// and fillable holes that produces bump/ground sensor values from the lemming's walk commands.
module lemming_world #(
  parameter int                 N_CELLS     = 16,
  parameter int                 START_POS   = 8,
  parameter logic [N_CELLS-1:0] HOLE_INIT   = 16'h0410,
  parameter int                 FALL_CYCLES = 3,
  localparam int                PW          = $clog2(N_CELLS)
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               walk_left,
  input  logic               walk_right,
  input  logic               aaah,
  input  logic               load,
  input  logic [PW-1:0]      load_pos,
  input  logic [N_CELLS-1:0] load_holes,
  output logic               bump_left,
  output logic               bump_right,
  output logic               ground,
  output logic [PW-1:0]      pos,
  output logic               falling,
  output logic [7:0]         falls,
  output logic               protocol_err
);

  localparam int            TW        = $clog2(FALL_CYCLES + 1);
  localparam logic [PW-1:0] LAST_POS  = PW'(N_CELLS - 1);
  localparam logic [PW-1:0] RST_POS   = PW'(START_POS);
  localparam logic [TW-1:0] FALL_LOAD = TW'(FALL_CYCLES);

  typedef enum logic {
    ST_GROUND = 1'b0,
    ST_FALL   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [N_CELLS-1:0] holes_q, holes_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         falls_q, falls_d;
  logic               err_q, err_d;
  logic               step_left_s, step_right_s;

  // State register; reset aborts any fall and restores the original hole map.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_GROUND;
      pos_q   <= RST_POS;
      holes_q <= HOLE_INIT;
      timer_q <= '0;
      falls_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      holes_q <= holes_d;
      timer_q <= timer_d;
      falls_q <= falls_d;
      err_q   <= err_d;
    end
  end

  // A step needs exactly one walk direction, no aaah, and room before the wall.
  always_comb begin
    step_left_s  = !aaah && walk_left && !walk_right && (pos_q != '0);
    step_right_s = !aaah && walk_right && !walk_left && (pos_q != LAST_POS);
  end

  // Next-state logic; load overrides movement, falling and error tracking.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    holes_d = holes_q;
    timer_d = timer_q;
    falls_d = falls_q;
    err_d   = err_q;
    if (load) begin
      state_d = ST_GROUND;
      timer_d = '0;
      pos_d   = (load_pos > LAST_POS) ? LAST_POS : load_pos;
      holes_d = load_holes;
      err_d   = 1'b0;
    end else begin
      if (walk_left && walk_right) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      case (state_q)
        ST_GROUND: begin
          if (holes_q[pos_q]) begin
            state_d = ST_FALL;
            timer_d = FALL_LOAD;
          end else if (step_left_s) begin
            pos_d = pos_q - PW'(1);
          end else if (step_right_s) begin
            pos_d = pos_q + PW'(1);
          end else begin
            pos_d = pos_q;
          end
        end
        ST_FALL: begin
          timer_d = timer_q - TW'(1);
          // Landing fills the hole the lemming fell through.
          if (timer_q == TW'(1)) begin
            state_d         = ST_GROUND;
            holes_d[pos_q]  = 1'b0;
            falls_d         = (falls_q == 8'hFF) ? falls_q : falls_q + 8'd1;
          end else begin
            state_d = ST_FALL;
          end
        end
        default: begin
          state_d = ST_GROUND;
          timer_d = '0;
        end
      endcase
    end
  end

  // Sensor outputs depend on registers only, so a Moore controller closes no combinational loop.
  always_comb begin
    ground       = (state_q == ST_GROUND) && !holes_q[pos_q];
    bump_left    = ground && (pos_q == '0);
    bump_right   = ground && (pos_q == LAST_POS);
    falling      = (state_q == ST_FALL);
    pos          = pos_q;
    falls        = falls_q;
    protocol_err = err_q;
  end

endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world: a queue-based scoreboard fed by a cell-level world model and a
// simple lemming controller model, plus a second small instance to exercise load clamping.
module tb_lemming_world;

  localparam int N  = 16;
  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        areset, walk_left, walk_right, aaah, load;
  logic [3:0]  load_pos;
  logic [15:0] load_holes;
  logic        bump_left, bump_right, ground, falling, protocol_err;
  logic [3:0]  pos;
  logic [7:0]  falls;

  logic        c_load;
  logic [3:0]  c_load_pos;
  logic        c_bl, c_br, c_ground, c_falling, c_err;
  logic [3:0]  c_pos;
  logic [7:0]  c_falls;

  always #5 clk = ~clk;

  lemming_world dut (
    .clk(clk), .areset(areset), .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .load(load), .load_pos(load_pos), .load_holes(load_holes),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .pos(pos),
    .falling(falling), .falls(falls), .protocol_err(protocol_err)
  );

  lemming_world #(.N_CELLS(12), .START_POS(3), .HOLE_INIT(12'h000), .FALL_CYCLES(1)) u_clamp (
    .clk(clk), .areset(areset), .walk_left(1'b0), .walk_right(1'b0), .aaah(1'b0),
    .load(c_load), .load_pos(c_load_pos), .load_holes(12'h000),
    .bump_left(c_bl), .bump_right(c_br), .ground(c_ground), .pos(c_pos),
    .falling(c_falling), .falls(c_falls), .protocol_err(c_err)
  );

  typedef struct {
    int pos;
    bit ground;
    bit bl;
    bit br;
    bit falling;
    int falls;
    bit err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // World model: cell index, hole bits, cycles of fall remaining (0 = standing).
  int          m_pos;
  logic [15:0] m_holes;
  int          m_fall;
  int          m_falls;
  bit          m_err;

  // Lemming controller model: direction 0 = left, 1 = right.
  int lem_dir  = 0;
  bit lem_fall = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pos     = m_pos;
    e.falling = (m_fall > 0);
    e.ground  = !e.falling && !m_holes[m_pos];
    e.bl      = e.ground && (m_pos == 0);
    e.br      = e.ground && (m_pos == N - 1);
    e.falls   = m_falls;
    e.err     = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_pos   = 8;
    m_holes = 16'h0410;
    m_fall  = 0;
    m_falls = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_advance(input bit wl, input bit wr, input bit ah, input bit ld,
                               input int lp, input logic [15:0] lh);
    if (ld) begin
      m_pos   = (lp > N - 1) ? N - 1 : lp;
      m_holes = lh;
      m_fall  = 0;
      m_err   = 1'b0;
    end else begin
      if (wl && wr) m_err = 1'b1;
      if (m_fall > 0) begin
        if (m_fall == 1) begin
          m_holes[m_pos] = 1'b0;
          if (m_falls < 255) m_falls++;
        end
        m_fall--;
      end else if (m_holes[m_pos]) begin
        m_fall = FC;
      end else if (!ah && wl && !wr && m_pos > 0) begin
        m_pos--;
      end else if (!ah && wr && !wl && m_pos < N - 1) begin
        m_pos++;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs.
  task automatic step(input bit r, input bit wl, input bit wr, input bit ah, input bit ld,
                      input int lp, input logic [15:0] lh);
    @(negedge clk);
    areset     = r;
    walk_left  = wl;
    walk_right = wr;
    aaah       = ah;
    load       = ld;
    load_pos   = lp[3:0];
    load_holes = lh;
    if (r) model_reset();
    else   model_advance(wl, wr, ah, ld, lp, lh);
    q.push_back(model_out());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
  endtask

  // One closed-loop cycle: lemming outputs come from its state, its next state from world sensors.
  task automatic lem_step();
    exp_t cur;
    bit   wl, wr, ah;
    cur = model_out();
    wl  = !lem_fall && (lem_dir == 0);
    wr  = !lem_fall && (lem_dir == 1);
    ah  = lem_fall;
    if (lem_fall) begin
      if (cur.ground) lem_fall = 1'b0;
    end else if (!cur.ground) begin
      lem_fall = 1'b1;
    end else if (lem_dir == 0 && cur.bl) begin
      lem_dir = 1;
    end else if (lem_dir == 1 && cur.br) begin
      lem_dir = 0;
    end
    step(1'b0, wl, wr, ah, 1'b0, 0, 16'h0000);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compares DUT outputs just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pos", int'(pos), e.pos);
        check("ground", int'(ground), int'(e.ground));
        check("bump_left", int'(bump_left), int'(e.bl));
        check("bump_right", int'(bump_right), int'(e.br));
        check("falling", int'(falling), int'(e.falling));
        check("falls", int'(falls), e.falls);
        check("protocol_err", int'(protocol_err), int'(e.err));
      end
    end
  end

  initial begin
    int r, d;
    bit wl, wr, ah, ld, rs;
    areset     = 1'b1;
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    load       = 1'b0;
    load_pos   = 4'd0;
    load_holes = 16'h0000;
    c_load     = 1'b0;
    c_load_pos = 4'd0;
    model_reset();

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
    #1;
    check("reset_ground", int'(ground), 1);
    check("reset_pos", int'(pos), 8);

    repeat (4) lem_step();
    after_edge();
    check("walk_to_4", int'(pos), 4);
    check("over_hole_ground", int'(ground), 0);
    repeat (4) lem_step();
    after_edge();
    check("land_ground", int'(ground), 1);
    check("land_falls", int'(falls), 1);
    check("land_pos", int'(pos), 4);
    repeat (60) lem_step();
    after_edge();
    check("second_fall", int'(falls), 2);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15, 16'h0000);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 16'h0000);
    after_edge();
    check("right_wall_pos", int'(pos), 15);
    check("right_wall_bump", int'(bump_right), 1);

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 16'h0000);
    after_edge();
    check("both_err", int'(protocol_err), 1);
    check("both_pos", int'(pos), 15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 16'h0000);
    after_edge();
    check("load_clears_err", int'(protocol_err), 0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 16'h0010);
    idle();
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
    #1;
    check("midfall_rst_falling", int'(falling), 0);
    check("midfall_rst_pos", int'(pos), 8);
    check("midfall_rst_ground", int'(ground), 1);
    check("midfall_rst_falls", int'(falls), 0);
    idle();

    repeat (300) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 16'h0010);
      repeat (4) idle();
    end
    after_edge();
    check("falls_saturate", int'(falls), 255);

    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      d  = $urandom_range(0, 9);
      ld = (r < 3);
      rs = ($urandom_range(0, 299) == 0);
      wl = (d <= 3) || (d == 9);
      wr = (d >= 4 && d <= 7) || (d == 9);
      ah = ($urandom_range(0, 7) == 0);
      step(rs, wl, wr, ah, ld, $urandom_range(0, 15), 16'($urandom & $urandom & $urandom));
    end
    idle();

    @(negedge clk);
    c_load     = 1'b1;
    c_load_pos = 4'd14;
    after_edge();
    check("clamp_pos", int'(c_pos), 11);
    check("clamp_bump_right", int'(c_br), 1);
    @(negedge clk);
    c_load_pos = 4'd9;
    after_edge();
    check("in_range_pos", int'(c_pos), 9);
    @(negedge clk);
    c_load = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) after_edge();
    if (q.size() != 0) begin
      check("scoreboard_drain", q.size(), 0);
    end else begin
      checks++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
